// File: rtl/attacker_array.sv
// attacker_array: NUM_ATK attackers that chase the shooter once per move tick,
// die on bullet hits, respawn at an LFSR-chosen column and drive the sprite
// hit flag for the colour mux. Position/timer updates are swept one attacker
// per cycle during vertical blanking; the pixel compare runs in parallel.
module attacker_array #(
    parameter int NUM_ATK        = 6,
    parameter int COORD_W        = 17,
    parameter int H_RES          = 1024,
    parameter int V_RES          = 768,
    parameter int ATK_HALF       = 8,
    parameter int STEP           = 2,
    parameter int MOVE_DIV       = 2,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic                 clk_65M,
    input  logic                 clear,
    input  logic [COORD_W-1:0]   H_count,
    input  logic [COORD_W-1:0]   V_count,
    input  logic                 vid_on,
    input  logic [COORD_W-1:0]   shooter_xmid,
    input  logic [COORD_W-1:0]   shooter_ymid,
    input  logic                 game_stop,
    input  logic                 hit_valid,
    input  logic [COORD_W-1:0]   hit_x,
    input  logic [COORD_W-1:0]   hit_y,
    output logic                 atk_on,
    output logic [3:0]           atk_id,
    output logic [NUM_ATK-1:0]   atk_active,
    output logic [7:0]           kill_count,
    output logic                 game_over
);

    localparam logic [COORD_W-1:0] HALF_C    = COORD_W'(ATK_HALF);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] COLL_C    = COORD_W'(2 * ATK_HALF);
    localparam logic [COORD_W-1:0] V_RES_C   = COORD_W'(V_RES);
    localparam logic [15:0]        SPAN_C    = 16'(H_RES - 2 * ATK_HALF);
    localparam logic [3:0]         LAST_IDX  = 4'(NUM_ATK - 1);
    localparam logic [7:0]         MOVE_LAST = 8'(MOVE_DIV - 1);
    localparam logic [7:0]         RESP_LAST = 8'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, CHECK} state_t;

    // Unsigned distance without wrap: compare first, then subtract.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // One axis of motion: snap onto the target when within STEP, else step toward it.
    function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] pos,
                                                       input logic [COORD_W-1:0] target);
        if (abs_diff(pos, target) <= STEP_C)
            return target;
        else if (pos > target)
            return pos - STEP_C;
        else
            return pos + STEP_C;
    endfunction

    function automatic logic [COORD_W-1:0] init_x(input int i);
        return COORD_W'((i + 1) * H_RES / (NUM_ATK + 1));
    endfunction

    state_t               state_reg, state_next;
    logic [3:0]           idx_reg;
    logic                 tick_cond_reg;
    logic [7:0]           move_cnt_reg;
    logic                 move_sweep_reg;
    logic [15:0]          lfsr_reg;
    logic                 game_over_reg;
    logic [7:0]           kill_count_reg;
    logic                 pend_valid_reg;
    logic [COORD_W-1:0]   pend_x_reg, pend_y_reg;
    logic                 atk_on_reg;
    logic [3:0]           atk_id_reg;

    logic [COORD_W-1:0]   x_reg     [NUM_ATK];
    logic [COORD_W-1:0]   y_reg     [NUM_ATK];
    logic [7:0]           timer_reg [NUM_ATK];
    logic [NUM_ATK-1:0]   active_reg;

    logic                 tick_cond, frame_tick;
    logic                 run_ok, upd_en, do_move, do_respawn, collide, apply_hit;
    logic [COORD_W-1:0]   cur_x, cur_y, next_x, next_y, spawn_x;
    logic                 cur_active;
    logic [7:0]           cur_timer;
    logic [15:0]          spawn_off;
    logic [NUM_ATK-1:0]   pix_hit, hit_match, kill_vec;
    logic [3:0]           pix_id;

    assign tick_cond  = (H_count == '0) && (V_count == V_RES_C);
    assign frame_tick = tick_cond && !tick_cond_reg;
    assign run_ok     = !game_stop && !game_over_reg;
    assign upd_en     = (state_reg == UPDATE) && run_ok;
    assign apply_hit  = pend_valid_reg && (state_reg != UPDATE) && !game_over_reg;
    assign spawn_off  = lfsr_reg % SPAN_C;
    assign spawn_x    = HALF_C + COORD_W'(spawn_off);

    // Per-attacker parallel compares: sprite coverage and bullet proximity.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ATK; gi++) begin : g_cmp
            assign pix_hit[gi]   = active_reg[gi] && vid_on &&
                                   (abs_diff(H_count, x_reg[gi]) < HALF_C) &&
                                   (abs_diff(V_count, y_reg[gi]) < HALF_C);
            assign hit_match[gi] = active_reg[gi] &&
                                   (abs_diff(x_reg[gi], pend_x_reg) <= HALF_C) &&
                                   (abs_diff(y_reg[gi], pend_y_reg) <= HALF_C);
        end
    endgenerate

    // Pick out the attacker under the sweep pointer and compute its move.
    always_comb begin
        cur_x      = '0;
        cur_y      = '0;
        cur_active = 1'b0;
        cur_timer  = '0;
        for (int i = 0; i < NUM_ATK; i++) begin
            if (idx_reg == 4'(i)) begin
                cur_x      = x_reg[i];
                cur_y      = y_reg[i];
                cur_active = active_reg[i];
                cur_timer  = timer_reg[i];
            end
        end
        next_x     = step_toward(cur_x, shooter_xmid);
        next_y     = step_toward(cur_y, shooter_ymid);
        collide    = (abs_diff(next_x, shooter_xmid) < COLL_C) &&
                     (abs_diff(next_y, shooter_ymid) < COLL_C);
        do_move    = upd_en && cur_active && move_sweep_reg;
        do_respawn = upd_en && !cur_active && (cur_timer == RESP_LAST);
    end

    // Lowest-index match wins; only one kill per bullet.
    always_comb begin
        kill_vec = '0;
        for (int i = NUM_ATK - 1; i >= 0; i--) begin
            if (apply_hit && hit_match[i]) begin
                kill_vec    = '0;
                kill_vec[i] = 1'b1;
            end
        end
    end

    // Lowest-index sprite wins for the colour mux.
    always_comb begin
        pix_id = '0;
        for (int i = NUM_ATK - 1; i >= 0; i--) begin
            if (pix_hit[i])
                pix_id = 4'(i);
        end
    end

    // Sweep FSM next-state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_tick && !game_stop && !game_over_reg) state_next = UPDATE;
            UPDATE:  if (idx_reg == LAST_IDX) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM, sweep pointer, move divider, LFSR, hit latch and scoring state.
    always_ff @(posedge clk_65M) begin
        if (clear) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            tick_cond_reg  <= 1'b0;
            move_cnt_reg   <= '0;
            move_sweep_reg <= 1'b0;
            lfsr_reg       <= 16'hACE1;
            game_over_reg  <= 1'b0;
            kill_count_reg <= '0;
            pend_valid_reg <= 1'b0;
            pend_x_reg     <= '0;
            pend_y_reg     <= '0;
            atk_on_reg     <= 1'b0;
            atk_id_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            tick_cond_reg <= tick_cond;
            atk_on_reg    <= |pix_hit;
            atk_id_reg    <= pix_id;
            idx_reg       <= (state_reg == UPDATE && idx_reg != LAST_IDX) ? idx_reg + 4'd1 : 4'd0;
            if (state_reg == IDLE && state_next == UPDATE) begin
                move_sweep_reg <= (move_cnt_reg == 8'd0);
                move_cnt_reg   <= (move_cnt_reg == MOVE_LAST) ? 8'd0 : move_cnt_reg + 8'd1;
            end
            if (do_respawn)
                lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
            if (do_move && collide)
                game_over_reg <= 1'b1;
            if (hit_valid && !game_over_reg) begin
                pend_valid_reg <= 1'b1;
                pend_x_reg     <= hit_x;
                pend_y_reg     <= hit_y;
            end else if (apply_hit) begin
                pend_valid_reg <= 1'b0;
            end
            if (|kill_vec && kill_count_reg != 8'hFF)
                kill_count_reg <= kill_count_reg + 8'd1;
        end
    end

    // Attacker positions, alive flags and respawn timers.
    always_ff @(posedge clk_65M) begin
        for (int i = 0; i < NUM_ATK; i++) begin
            if (clear) begin
                x_reg[i]      <= init_x(i);
                y_reg[i]      <= HALF_C;
                active_reg[i] <= 1'b1;
                timer_reg[i]  <= '0;
            end else if (upd_en && idx_reg == 4'(i)) begin
                if (do_move) begin
                    x_reg[i] <= next_x;
                    y_reg[i] <= next_y;
                end else if (do_respawn) begin
                    active_reg[i] <= 1'b1;
                    timer_reg[i]  <= '0;
                    x_reg[i]      <= spawn_x;
                    y_reg[i]      <= HALF_C;
                end else if (!cur_active) begin
                    timer_reg[i] <= timer_reg[i] + 8'd1;
                end
            end else if (kill_vec[i]) begin
                active_reg[i] <= 1'b0;
                timer_reg[i]  <= '0;
            end
        end
    end

    assign atk_on     = atk_on_reg;
    assign atk_id     = atk_id_reg;
    assign atk_active = active_reg;
    assign kill_count = kill_count_reg;
    assign game_over  = game_over_reg;

endmodule
